// File: rtl/bht_if.sv
// Lookup/update/flush bundle between fetch/execute and branch_history_table.
// Optional statistics outputs are present only when BHT_STATS_EN is defined.
interface bht_if #(
    parameter int ADDR_W = 10
);
    logic              BHT_FLUSH;
    logic              BHT_LU_VALID;
    logic              BHT_LU_COND;
    logic              BHT_LU_UNCOND;
    logic [ADDR_W-1:0] BHT_LU_ADDR;
    logic              BHT_PC_LD;
    logic              BHT_PC_SEL;
    logic              BHT_PRED_TAKEN;
    logic              BHT_PRED_HIT;
    logic              BHT_UP_VALID;
    logic [ADDR_W-1:0] BHT_UP_ADDR;
    logic              BHT_UP_TAKEN;
    logic              BHT_UP_MISPRED;
`ifdef BHT_STATS_EN
    logic [15:0]       BHT_STAT_UPD;
    logic [15:0]       BHT_STAT_MISPRED;

    modport master (
        output BHT_FLUSH, BHT_LU_VALID, BHT_LU_COND, BHT_LU_UNCOND, BHT_LU_ADDR,
        output BHT_UP_VALID, BHT_UP_ADDR, BHT_UP_TAKEN, BHT_UP_MISPRED,
        input  BHT_PC_LD, BHT_PC_SEL, BHT_PRED_TAKEN, BHT_PRED_HIT,
        input  BHT_STAT_UPD, BHT_STAT_MISPRED
    );

    modport slave (
        input  BHT_FLUSH, BHT_LU_VALID, BHT_LU_COND, BHT_LU_UNCOND, BHT_LU_ADDR,
        input  BHT_UP_VALID, BHT_UP_ADDR, BHT_UP_TAKEN, BHT_UP_MISPRED,
        output BHT_PC_LD, BHT_PC_SEL, BHT_PRED_TAKEN, BHT_PRED_HIT,
        output BHT_STAT_UPD, BHT_STAT_MISPRED
    );
`else
    modport master (
        output BHT_FLUSH, BHT_LU_VALID, BHT_LU_COND, BHT_LU_UNCOND, BHT_LU_ADDR,
        output BHT_UP_VALID, BHT_UP_ADDR, BHT_UP_TAKEN, BHT_UP_MISPRED,
        input  BHT_PC_LD, BHT_PC_SEL, BHT_PRED_TAKEN, BHT_PRED_HIT
    );

    modport slave (
        input  BHT_FLUSH, BHT_LU_VALID, BHT_LU_COND, BHT_LU_UNCOND, BHT_LU_ADDR,
        input  BHT_UP_VALID, BHT_UP_ADDR, BHT_UP_TAKEN, BHT_UP_MISPRED,
        output BHT_PC_LD, BHT_PC_SEL, BHT_PRED_TAKEN, BHT_PRED_HIT
    );
`endif
endinterface

// File: rtl/branch_history_table.sv
// Fully associative branch history table with saturating counters, round-robin
// replacement and zero-latency lookup. Define BHT_STATS_EN for update statistics.
module branch_history_table #(
    parameter int ENTRIES = 4,
    parameter int ADDR_W  = 10,
    parameter int CNT_W   = 2
) (
    input  logic BHT_CLK,
    input  logic BHT_RST,
    bht_if.slave bus
);
    localparam int               PTR_W       = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_WEAK_T  = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_WEAK_NT = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [PTR_W-1:0] PTR_LAST    = PTR_W'(ENTRIES - 1);

    logic [ENTRIES-1:0] valid;
    logic [ADDR_W-1:0]  tag [ENTRIES];
    logic [CNT_W-1:0]   cnt [ENTRIES];
    logic [PTR_W-1:0]   rr_ptr;

    logic               lu_hit;
    logic [PTR_W-1:0]   lu_idx;
    logic               up_hit;
    logic [PTR_W-1:0]   up_idx;
    logic               has_free;
    logic [PTR_W-1:0]   free_idx;
    logic [PTR_W-1:0]   victim;
    logic               pred_taken;
    logic               pc_ld;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        lu_hit   = 1'b0;
        lu_idx   = '0;
        up_hit   = 1'b0;
        up_idx   = '0;
        has_free = 1'b0;
        free_idx = '0;
        // Descending scan: the last assignment wins, leaving the lowest index.
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid[i] && tag[i] == bus.BHT_LU_ADDR) begin
                lu_hit = 1'b1;
                lu_idx = PTR_W'(i);
            end
            if (valid[i] && tag[i] == bus.BHT_UP_ADDR) begin
                up_hit = 1'b1;
                up_idx = PTR_W'(i);
            end
            if (!valid[i]) begin
                has_free = 1'b1;
                free_idx = PTR_W'(i);
            end
        end
    end

    assign victim = has_free ? free_idx : rr_ptr;

    // A conditional miss predicts static taken; unconditional never reports taken.
    always_comb begin
        pred_taken = bus.BHT_LU_VALID & ~bus.BHT_LU_UNCOND & bus.BHT_LU_COND &
                     (lu_hit ? cnt[lu_idx][CNT_W-1] : 1'b1);
        pc_ld      = bus.BHT_LU_VALID & (bus.BHT_LU_UNCOND | pred_taken);
    end

    assign bus.BHT_PRED_TAKEN = pred_taken;
    assign bus.BHT_PRED_HIT   = bus.BHT_LU_VALID & lu_hit;
    assign bus.BHT_PC_LD      = pc_ld;
    assign bus.BHT_PC_SEL     = pc_ld;

    always_ff @(posedge BHT_CLK or posedge BHT_RST) begin
        if (BHT_RST) begin
            valid  <= '0;
            rr_ptr <= '0;
            // NOTE: the table arrays carry defined reset values, so they reset with the flops.
            for (int i = 0; i < ENTRIES; i++) begin
                tag[i] <= '0;
                cnt[i] <= CNT_WEAK_T;
            end
        end else if (bus.BHT_FLUSH) begin
            valid  <= '0;
            rr_ptr <= '0;
        end else if (bus.BHT_UP_VALID) begin
            // NOTE: non-blocking writes keep same-cycle lookups on pre-edge state.
            if (up_hit) begin
                if (bus.BHT_UP_TAKEN && cnt[up_idx] != CNT_MAX)
                    cnt[up_idx] <= cnt[up_idx] + CNT_W'(1);
                else if (!bus.BHT_UP_TAKEN && cnt[up_idx] != '0)
                    cnt[up_idx] <= cnt[up_idx] - CNT_W'(1);
            end else begin
                valid[victim] <= 1'b1;
                tag[victim]   <= bus.BHT_UP_ADDR;
                cnt[victim]   <= bus.BHT_UP_TAKEN ? CNT_WEAK_T : CNT_WEAK_NT;
                if (!has_free)
                    rr_ptr <= (rr_ptr == PTR_LAST) ? '0 : rr_ptr + PTR_W'(1);
            end
        end
    end

`ifdef BHT_STATS_EN
    logic [15:0] stat_upd;
    logic [15:0] stat_mispred;

    always_ff @(posedge BHT_CLK or posedge BHT_RST) begin
        if (BHT_RST) begin
            stat_upd     <= '0;
            stat_mispred <= '0;
        end else if (bus.BHT_UP_VALID && !bus.BHT_FLUSH) begin
            if (stat_upd != 16'hFFFF)
                stat_upd <= stat_upd + 16'd1;
            if (bus.BHT_UP_MISPRED && stat_mispred != 16'hFFFF)
                stat_mispred <= stat_mispred + 16'd1;
        end
    end

    assign bus.BHT_STAT_UPD     = stat_upd;
    assign bus.BHT_STAT_MISPRED = stat_mispred;
`else
    logic unused_mispred;
    assign unused_mispred = bus.BHT_UP_MISPRED;
`endif
endmodule

// File: tb/tb_branch_history_table.sv
// Directed bench for branch_history_table (ENTRIES=4, CNT_W=2, ADDR_W=10);
// lookup expectations go through a scoreboard queue. Honours BHT_STATS_EN.
module tb_branch_history_table;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [3:0] exp_q [$];
    string      tag_q [$];

    bht_if #(.ADDR_W(10)) bus ();

    branch_history_table #(.ENTRIES(4), .ADDR_W(10), .CNT_W(2)) dut (
        .BHT_CLK (clk),
        .BHT_RST (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected vector order: {hit, taken, pc_ld, pc_sel}.
    task automatic push_lookup(input string tag, input logic lv, input logic uncond,
                               input logic e_hit, input logic e_taken);
        logic e_pc;
        e_pc = lv & (uncond | e_taken);
        exp_q.push_back({e_hit, e_taken, e_pc, e_pc});
        tag_q.push_back(tag);
    endtask

    task automatic pop_compare();
        logic [3:0] obs;
        obs = {bus.BHT_PRED_HIT, bus.BHT_PRED_TAKEN, bus.BHT_PC_LD, bus.BHT_PC_SEL};
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard observed=empty expected=entry");
        end else begin
            check(tag_q.pop_front(), {28'b0, obs}, {28'b0, exp_q.pop_front()});
        end
    endtask

    task automatic drive_lookup(input logic [9:0] a, input logic cond,
                                input logic uncond, input logic lv);
        bus.BHT_LU_VALID  = lv;
        bus.BHT_LU_COND   = cond;
        bus.BHT_LU_UNCOND = uncond;
        bus.BHT_LU_ADDR   = a;
    endtask

    task automatic lookup(input string tag, input logic [9:0] a, input logic cond,
                          input logic uncond, input logic lv,
                          input logic e_hit, input logic e_taken);
        @(negedge clk);
        drive_lookup(a, cond, uncond, lv);
        push_lookup(tag, lv, uncond, e_hit, e_taken);
        #2 pop_compare();
    endtask

    task automatic clear_update();
        bus.BHT_UP_VALID   = 1'b0;
        bus.BHT_UP_TAKEN   = 1'b0;
        bus.BHT_UP_MISPRED = 1'b0;
        bus.BHT_FLUSH      = 1'b0;
    endtask

    task automatic update(input logic [9:0] a, input logic taken,
                          input logic mis, input logic flush);
        @(negedge clk);
        bus.BHT_UP_VALID   = 1'b1;
        bus.BHT_UP_ADDR    = a;
        bus.BHT_UP_TAKEN   = taken;
        bus.BHT_UP_MISPRED = mis;
        bus.BHT_FLUSH      = flush;
        @(posedge clk);
        #1 clear_update();
    endtask

    task automatic flush_only();
        @(negedge clk);
        bus.BHT_FLUSH = 1'b1;
        @(posedge clk);
        #1 clear_update();
    endtask

    initial begin
        rst = 1'b1;
        drive_lookup(10'h000, 1'b0, 1'b0, 1'b0);
        bus.BHT_UP_ADDR = '0;
        clear_update();
        #12 rst = 1'b0;

        // Reset state and static prediction
        lookup("rst_cond_miss",  10'h010, 1, 0, 1, 0, 1);
        lookup("lu_valid_low",   10'h010, 1, 0, 0, 0, 0);
        lookup("uncond_miss",    10'h010, 1, 1, 1, 0, 0);
        lookup("non_branch",     10'h010, 0, 0, 1, 0, 0);

        // Counter training and saturation at 0 and upward
        update(10'h010, 0, 0, 0);
        lookup("alloc_nt_01",    10'h010, 1, 0, 1, 1, 0);
        update(10'h010, 0, 0, 0);
        update(10'h010, 0, 0, 0);
        lookup("sat_low_00",     10'h010, 1, 0, 1, 1, 0);
        update(10'h010, 1, 0, 0);
        lookup("inc_to_01",      10'h010, 1, 0, 1, 1, 0);
        update(10'h010, 1, 0, 0);
        lookup("inc_to_10",      10'h010, 1, 0, 1, 1, 1);
        lookup("uncond_hit",     10'h010, 1, 1, 1, 1, 0);

        // Allocation and round-robin replacement
        flush_only();
        lookup("flush_miss",     10'h010, 1, 0, 1, 0, 1);
        for (int i = 1; i <= 4; i++) update(10'(i), 1, 0, 0);
        lookup("fill_hit_004",   10'h004, 1, 0, 1, 1, 1);
        update(10'h005, 0, 0, 0);
        lookup("evicted_001",    10'h001, 1, 0, 1, 0, 1);
        lookup("new_005_nt",     10'h005, 1, 0, 1, 1, 0);
        update(10'h006, 1, 0, 0);
        lookup("evicted_002",    10'h002, 1, 0, 1, 0, 1);
        lookup("new_006",        10'h006, 1, 0, 1, 1, 1);
        lookup("kept_003",       10'h003, 1, 0, 1, 1, 1);

        // Same-cycle lookup and update: no bypass
        @(negedge clk);
        drive_lookup(10'h003, 1'b1, 1'b0, 1'b1);
        bus.BHT_UP_VALID = 1'b1;
        bus.BHT_UP_ADDR  = 10'h003;
        bus.BHT_UP_TAKEN = 1'b0;
        push_lookup("same_cycle_pre", 1, 0, 1, 1);
        #2 pop_compare();
        @(posedge clk);
        #1 clear_update();
        push_lookup("same_cycle_post", 1, 0, 1, 0);
        #1 pop_compare();

        // Flush wins over a same-cycle update; pointer restarts at 0
        update(10'h020, 1, 0, 1);
        lookup("flush_upd_003",  10'h003, 1, 0, 1, 0, 1);
        lookup("flush_upd_020",  10'h020, 1, 0, 1, 0, 1);
        for (int i = 1; i <= 4; i++) update(10'(10'h030 + i), 0, 0, 0);
        update(10'h035, 1, 0, 0);
        lookup("ptr_clr_031",    10'h031, 1, 0, 1, 0, 1);
        lookup("ptr_clr_032",    10'h032, 1, 0, 1, 1, 0);
        lookup("ptr_clr_035",    10'h035, 1, 0, 1, 1, 1);

        // Reset mid-update aborts it; first edge afterwards works
        @(negedge clk);
        drive_lookup(10'h032, 1'b1, 1'b0, 1'b1);
        bus.BHT_UP_VALID = 1'b1;
        bus.BHT_UP_ADDR  = 10'h040;
        bus.BHT_UP_TAKEN = 1'b1;
        rst = 1'b1;
        push_lookup("async_rst_miss", 1, 0, 0, 1);
        #2 pop_compare();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 clear_update();
        lookup("post_rst_alloc", 10'h040, 1, 0, 1, 1, 1);
        lookup("post_rst_032",   10'h032, 1, 0, 1, 0, 1);

`ifdef BHT_STATS_EN
        update(10'h041, 1, 1, 0);
        update(10'h042, 0, 0, 0);
        #1;
        check("stat_upd_3",     {16'b0, bus.BHT_STAT_UPD},     32'd3);
        check("stat_mispred_1", {16'b0, bus.BHT_STAT_MISPRED}, 32'd1);
        update(10'h043, 1, 1, 1);
        #1;
        check("stat_upd_flush", {16'b0, bus.BHT_STAT_UPD},     32'd3);
        check("stat_mis_flush", {16'b0, bus.BHT_STAT_MISPRED}, 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("stat_upd_rst",   {16'b0, bus.BHT_STAT_UPD},     32'd0);
        check("stat_mis_rst",   {16'b0, bus.BHT_STAT_MISPRED}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
`endif

        @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_history_table.md
BRANCH_HISTORY_TABLE -- requirements
Module: branch_history_table

Interface
REQ-001 SHALL have parameter ENTRIES, default 4, number of tagged table entries (>=2, any integer).
REQ-002 SHALL have parameter ADDR_W, default 10, instruction address width.
REQ-003 SHALL have parameter CNT_W, default 2, saturating counter width (>=2).
REQ-004 SHALL have port BHT_CLK  in  1  clock, all state on rising edge.
REQ-005 SHALL have port BHT_RST  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have port BHT_FLUSH  in  1  synchronous invalidate of all entries.
REQ-007 SHALL have port BHT_LU_VALID  in  1  fetch slot holds a live (non-NOP) instruction.
REQ-008 SHALL have port BHT_LU_COND  in  1  fetched instruction is a conditional branch.
REQ-009 SHALL have port BHT_LU_UNCOND  in  1  fetched instruction is BRN or CALL.
REQ-010 SHALL have port BHT_LU_ADDR  in  ADDR_W  address of fetched instruction.
REQ-011 SHALL have port BHT_PC_LD  out  1  load PC from branch target.
REQ-012 SHALL have port BHT_PC_SEL  out  1  PC mux select for branch target; always equals BHT_PC_LD.
REQ-013 SHALL have port BHT_PRED_TAKEN  out  1  conditional branch predicted taken.
REQ-014 SHALL have port BHT_PRED_HIT  out  1  lookup address matched a valid entry.
REQ-015 SHALL have port BHT_UP_VALID  in  1  resolved conditional branch in execute, not NOP'd.
REQ-016 SHALL have port BHT_UP_ADDR  in  ADDR_W  address of resolved branch.
REQ-017 SHALL have port BHT_UP_TAKEN  in  1  actual branch outcome.
REQ-018 SHALL have port BHT_UP_MISPRED  in  1  resolved outcome differed from prediction (statistics only).

Function
REQ-019 Lookup SHALL be combinational from registered table state (zero-cycle latency); BHT_LU_VALID=0 forces all outputs to 0.
REQ-020 Hit SHALL mean BHT_LU_ADDR equals the stored address of a valid entry; multiple matches resolve to the lowest index.
REQ-021 BHT_LU_UNCOND=1 SHALL set PC_LD=1, PRED_TAKEN=0, regardless of BHT_LU_COND or hit state.
REQ-022 BHT_LU_COND=1 with hit SHALL set PRED_TAKEN to the counter MSB; with miss, PRED_TAKEN=1 (static taken).
REQ-023 BHT_PC_LD SHALL equal LU_VALID and (LU_UNCOND or PRED_TAKEN).
REQ-024 Update on hit SHALL increment (taken) or decrement (not taken) the counter, saturating at 2^CNT_W-1 and 0.
REQ-025 Update on miss SHALL allocate: store BHT_UP_ADDR, set valid, load counter 2^(CNT_W-1) if taken else 2^(CNT_W-1)-1.
REQ-026 Allocation victim SHALL be the lowest-index invalid entry; if all valid, the entry at the round-robin pointer.
REQ-027 Round-robin pointer SHALL advance only when a valid entry is replaced, wrapping from ENTRIES-1 to 0.
REQ-028 Lookup and update in the same cycle to the same address SHALL see pre-edge state (no bypass).
REQ-029 BHT_FLUSH SHALL clear all valid bits and the pointer on the next edge; counters and addresses retain their values.
REQ-030 BHT_FLUSH and BHT_UP_VALID in the same cycle: flush wins, update dropped.

Reset
REQ-031 BHT_RST SHALL immediately clear valid bits, stored addresses and pointer to 0, set counters to 2^(CNT_W-1), and clear statistics.
REQ-032 Reset asserted mid-operation SHALL abort any pending update; the first edge after deassertion SHALL operate normally.

Configuration
REQ-033 With macro BHT_STATS_EN defined, the block SHALL add outputs BHT_STAT_UPD (16) and BHT_STAT_MISPRED (16).
REQ-034 BHT_STAT_UPD SHALL count accepted updates; BHT_STAT_MISPRED SHALL count accepted updates with UP_MISPRED=1; both saturate at 0xFFFF.
REQ-035 Without BHT_STATS_EN, those ports and their registers SHALL be absent; all other behaviour is identical.

Verification (ENTRIES=4, CNT_W=2, ADDR_W=10)
REQ-036 Reset, then lookup COND at 0x010 -> HIT=0, PRED_TAKEN=1, PC_LD=1, PC_SEL=1.
REQ-037 Update 0x010 not-taken three times -> counter 01, 00, 00; lookup gives HIT=1, TAKEN=0; two taken updates -> 10, TAKEN=1.
REQ-038 Allocate 0x001..0x004, then 0x005 -> 0x005 replaces entry 0; lookup 0x001 misses, pointer=1; 0x006 replaces entry 1.
REQ-039 Same-cycle lookup and update (not-taken) of hit entry at counter 10 -> lookup TAKEN=1 that cycle, TAKEN=0 next.
REQ-040 FLUSH with UP_VALID at new address 0x020 -> next cycle all lookups miss; 0x020 not allocated.
REQ-041 BHT_STATS_EN: 3 updates, one with MISPRED=1 -> UPD=3, MISPRED=1; assert BHT_RST mid-run -> both read 0 immediately.
